pia_fifo: RTL

- Parametrised successor to the single-character Apple-1 PIA: keyboard and display channels, each buffered by a FIFO, behind a 4-register window at a configurable base address.
- Sits between the 6502 core (address/data/WE) and the host-side keyboard/display handshakes.
- The top-level decoder routes DO to the CPU read bus when sel=1.

---
 rtl/pia_fifo_pkg.sv | 26 ++
 rtl/pia_fifo_if.sv | 52 +++++
 rtl/pia_fifo_sync_fifo.sv | 66 ++++++
 rtl/pia_fifo.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pia_fifo_pkg.sv
// pia_fifo shared definitions: register offsets, bit positions,
// keyboard handshake states and the window decode helper.
package pia_fifo_pkg;

    localparam logic [1:0] OFF_KBD   = 2'd0;
    localparam logic [1:0] OFF_KBDCR = 2'd1;
    localparam logic [1:0] OFF_DSP   = 2'd2;
    localparam logic [1:0] OFF_DSPCR = 2'd3;

    localparam int ST_BIT  = 7;
    localparam int OVF_BIT = 6;
    localparam int IE_BIT  = 0;

    typedef enum logic {
        K_IDLE,
        K_ACK
    } kst_e;

    function automatic logic win_hit(
        input logic [15:0] a,
        input logic [15:0] base
    );
        return a[15:2] == base[15:2];
    endfunction

endpackage

// File: rtl/pia_fifo_if.sv
// CPU bus and host keyboard/display handshake bundle for pia_fifo.
// Carries irq only when PIA_IRQ_EN is defined.
interface pia_fifo_if #(
    parameter int KBD_DEPTH = 16,
    parameter int DSP_DEPTH = 16,
    parameter int CHAR_W    = 7
);
    localparam int KCW = $clog2(KBD_DEPTH) + 1;
    localparam int DCW = $clog2(DSP_DEPTH) + 1;

    logic [15:0]       AB;
    logic              WE;
    logic              RDY;
    logic [7:0]        DI;
    logic [7:0]        DO;
    logic              sel;
    logic              kbd_rdy;
    logic              kbd_ack;
    logic [CHAR_W-1:0] kbd_data;
    logic              dsp_rdy;
    logic              dsp_ack;
    logic [CHAR_W-1:0] dsp_data;
    logic [KCW-1:0]    kbd_count;
    logic [DCW-1:0]    dsp_count;

`ifdef PIA_IRQ_EN
    logic              irq;

    modport slave (
        input  AB, WE, RDY, DI, kbd_rdy, kbd_data, dsp_ack,
        output DO, sel, kbd_ack, dsp_rdy, dsp_data,
        output kbd_count, dsp_count, irq
    );
    modport master (
        output AB, WE, RDY, DI, kbd_rdy, kbd_data, dsp_ack,
        input  DO, sel, kbd_ack, dsp_rdy, dsp_data,
        input  kbd_count, dsp_count, irq
    );
`else
    modport slave (
        input  AB, WE, RDY, DI, kbd_rdy, kbd_data, dsp_ack,
        output DO, sel, kbd_ack, dsp_rdy, dsp_data,
        output kbd_count, dsp_count
    );
    modport master (
        output AB, WE, RDY, DI, kbd_rdy, kbd_data, dsp_ack,
        input  DO, sel, kbd_ack, dsp_rdy, dsp_data,
        input  kbd_count, dsp_count
    );
`endif

endinterface

// File: rtl/pia_fifo_sync_fifo.sv
// First-word-fall-through FIFO with registered pointers and exact count.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter  int W     = 7,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic [AW:0]  count
);

    localparam logic [AW-1:0] P_ONE = 1;
    localparam logic [AW:0]   C_ONE = 1;
    localparam logic [AW:0]   C_MAX = DEPTH;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_pop;
    logic          do_push;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == C_MAX;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_q];
    assign count   = cnt_q;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_pop) rd_d = rd_q + P_ONE;
        if (do_push) wr_d = wr_q + P_ONE;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + C_ONE;
            2'b01:   cnt_d = cnt_q - C_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din;
    end

endmodule

// File: rtl/pia_fifo.sv
// FIFO-buffered keyboard/display PIA behind a 4-register CPU window.
// Define PIA_IRQ_EN to add the registered keyboard irq output.
module pia_fifo
    import pia_fifo_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hD010,
    parameter int          KBD_DEPTH = 16,
    parameter int          DSP_DEPTH = 16,
    parameter int          CHAR_W    = 7
) (
    input logic      clk,
    input logic      reset,
    pia_fifo_if.slave bus
);

    logic [15:0]       addr_q;
    logic              we_q;
    logic              rdy_q;
    logic              ack_q;
    logic              ie_q, ie_d;
    logic              ovf_q, ovf_d;
    kst_e              st_q, st_d;
    logic [CHAR_W-1:0] kbd_head;
    logic [CHAR_W-1:0] dsp_head;
    logic              kbd_full, kbd_empty;
    logic              dsp_full, dsp_empty;
    logic              kbd_push, kbd_pop;
    logic              dsp_push, dsp_pop;
    logic              wr, rd, dsp_wr;
    logic              unused_di;

    assign unused_di = ^bus.DI;

    // Writes decode the live address; reads use the registered one.
    assign wr       = win_hit(bus.AB, BASE_ADDR) & bus.WE & bus.RDY;
    assign bus.sel  = win_hit(addr_q, BASE_ADDR);
    assign rd       = bus.sel & ~we_q & rdy_q;
    assign kbd_pop  = rd & (addr_q[1:0] == OFF_KBD) & ~kbd_empty;
    assign dsp_wr   = wr & (bus.AB[1:0] == OFF_DSP);
    assign dsp_pop  = bus.dsp_ack & ~ack_q & ~dsp_empty;
    assign dsp_push = dsp_wr & (~dsp_full | dsp_pop);

    assign bus.dsp_rdy  = ~dsp_empty;
    assign bus.dsp_data = dsp_empty ? '0 : dsp_head;
    assign bus.kbd_ack  = st_q == K_ACK;

    always_comb begin
        ie_d  = ie_q;
        ovf_d = ovf_q;
        if (wr && bus.AB[1:0] == OFF_KBDCR)
            ie_d = bus.DI[IE_BIT];
        if (dsp_wr && dsp_full && !dsp_pop)
            ovf_d = 1'b1;
        else if (wr && bus.AB[1:0] == OFF_DSPCR && bus.DI[OVF_BIT])
            ovf_d = 1'b0;
    end

    always_comb begin
        st_d     = st_q;
        kbd_push = 1'b0;
        case (st_q)
            K_IDLE: begin
                if (bus.kbd_rdy && (!kbd_full || kbd_pop)) begin
                    kbd_push = 1'b1;
                    st_d     = K_ACK;
                end
            end
            K_ACK: begin
                if (!bus.kbd_rdy) st_d = K_IDLE;
            end
            default: st_d = K_IDLE;
        endcase
    end

    always_comb begin
        bus.DO = '0;
        if (bus.sel) begin
            unique case (addr_q[1:0])
                OFF_KBD: begin
                    if (!kbd_empty) bus.DO = {1'b1, 7'(kbd_head)};
                end
                OFF_KBDCR: begin
                    bus.DO[ST_BIT] = ~kbd_empty;
                    bus.DO[1]      = kbd_full;
                    bus.DO[IE_BIT] = ie_q;
                end
                OFF_DSP: begin
                    bus.DO[ST_BIT] = dsp_full;
                end
                OFF_DSPCR: begin
                    bus.DO[ST_BIT]  = ~dsp_empty;
                    bus.DO[OVF_BIT] = ovf_q;
                end
                default: bus.DO = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q <= '0;
            we_q   <= 1'b0;
            rdy_q  <= 1'b0;
            ack_q  <= 1'b0;
            ie_q   <= 1'b0;
            ovf_q  <= 1'b0;
            st_q   <= K_IDLE;
        end else begin
            addr_q <= bus.AB;
            we_q   <= bus.WE;
            rdy_q  <= bus.RDY;
            ack_q  <= bus.dsp_ack;
            ie_q   <= ie_d;
            ovf_q  <= ovf_d;
            st_q   <= st_d;
        end
    end

`ifdef PIA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!reset) irq_q <= 1'b0;
        else        irq_q <= ie_q & ~kbd_empty;
    end

    assign bus.irq = irq_q;
`endif

    sync_fifo #(
        .W    (CHAR_W),
        .DEPTH(KBD_DEPTH)
    ) u_kbd (
        .clk  (clk),
        .reset(reset),
        .push (kbd_push),
        .din  (bus.kbd_data),
        .pop  (kbd_pop),
        .dout (kbd_head),
        .full (kbd_full),
        .empty(kbd_empty),
        .count(bus.kbd_count)
    );

    sync_fifo #(
        .W    (CHAR_W),
        .DEPTH(DSP_DEPTH)
    ) u_dsp (
        .clk  (clk),
        .reset(reset),
        .push (dsp_push),
        .din  (bus.DI[CHAR_W-1:0]),
        .pop  (dsp_pop),
        .dout (dsp_head),
        .full (dsp_full),
        .empty(dsp_empty),
        .count(bus.dsp_count)
    );

endmodule
